sb_config_sequencer: RTL and testbench

SB_CONFIG_SEQUENCER -- requirements
Module: sb_config_sequencer

---
 rtl/sb_config_sequencer.sv | 149 ++++++++++++++
 tb/tb_sb_config_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_sequencer.sv
// sb_config_sequencer
// Loads switch-box configuration words into a row of tiles. It accepts single
// addressed write beats from a valid/ready stream, or on request sweeps a clear
// word through every tile, one tile per cycle.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   cfg_valid     config beat offered; taken when cfg_valid && cfg_ready
//   cfg_ready     high only in IDLE while no clear is requested
//   cfg_addr      target tile index of the beat
//   cfg_data      config word (2-bit mux select per tile output)
//   cfg_last      beat closes a configuration session
//   clear_start   request a bulk clear of all tiles (beats lose to it)
//   config_data   word broadcast to every tile; 0 whenever no strobe is active
//   config_en     per-tile load strobe, one-hot or zero
//   busy          state is not IDLE
//   done          one-cycle pulse when a session or a clear completes
//   err           sticky out-of-range address flag; a clear resets it
//
// NUM_TILES must not exceed 2**ADDR_W.
module sb_config_sequencer #(
    parameter int unsigned NUM_TILES     = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] CLEAR_VALUE   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [31:0]          cfg_data,
    input  logic                 cfg_last,
    input  logic                 clear_start,
    output logic [31:0]          config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StWrite, StSettle, StClear} state_e;

    localparam int unsigned AddrW1     = ADDR_W + 1;
    localparam int unsigned SettleW    = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SettleInit = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [AddrW1-1:0]    NumTilesW = AddrW1'(NUM_TILES);
    localparam logic [ADDR_W-1:0]    LastTile  = ADDR_W'(NUM_TILES - 1);
    localparam logic [NUM_TILES-1:0] TileOne   = NUM_TILES'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                last_q;
    logic [ADDR_W-1:0]   tile_cnt_q;
    logic [SettleW-1:0]  settle_cnt_q;
    logic                done_q;
    logic                err_q;

    logic addr_in_range;

    // Extra top bit so that NUM_TILES == 2**ADDR_W compares correctly.
    assign addr_in_range = ({1'b0, cfg_addr} < NumTilesW);

    assign cfg_ready = (state_q == StIdle) && !clear_start;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            tile_cnt_q   <= '0;
            settle_cnt_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_start) begin
                        state_q    <= StClear;
                        tile_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end else if (cfg_valid) begin
                        if (addr_in_range) begin
                            state_q <= StWrite;
                            addr_q  <= cfg_addr;
                            data_q  <= cfg_data;
                            last_q  <= cfg_last;
                        end else begin
                            // Dropped beat still closes its session if marked last.
                            err_q  <= 1'b1;
                            done_q <= cfg_last;
                        end
                    end
                end
                StWrite: begin
                    if (SETTLE_CYCLES > 0) begin
                        state_q      <= StSettle;
                        settle_cnt_q <= SettleW'(SettleInit);
                    end else begin
                        state_q <= StIdle;
                        done_q  <= last_q;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= StIdle;
                        done_q  <= last_q;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SettleW'(1);
                    end
                end
                StClear: begin
                    if (tile_cnt_q == LastTile) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        tile_cnt_q <= tile_cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    // Strobe and data decode straight from registered state, so both change
    // only on clock edges and data is forced to 0 whenever no strobe is up.
    always_comb begin
        config_en   = '0;
        config_data = '0;
        case (state_q)
            StWrite: begin
                config_en   = TileOne << addr_q;
                config_data = data_q;
            end
            StClear: begin
                config_en   = TileOne << tile_cnt_q;
                config_data = CLEAR_VALUE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sb_config_sequencer.sv
module tb_sb_config_sequencer;

    localparam logic [31:0] ClrVal = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cfg_valid, cfg_ready, cfg_last, clear_start;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data, config_data;
    logic [15:0] config_en;
    logic        busy, done, err;

    // Second instance with fewer tiles than the address space, for range errors.
    logic        v12, rdy12, last12, clr12, busy12, done12, err12;
    logic [3:0]  addr12;
    logic [31:0] data12, cdata12;
    logic [11:0] en12;

    sb_config_sequencer #(
        .NUM_TILES(16), .ADDR_W(4), .SETTLE_CYCLES(2), .CLEAR_VALUE(ClrVal)
    ) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .clear_start(clear_start), .config_data(config_data), .config_en(config_en),
        .busy(busy), .done(done), .err(err)
    );

    sb_config_sequencer #(
        .NUM_TILES(12), .ADDR_W(4), .SETTLE_CYCLES(2), .CLEAR_VALUE(ClrVal)
    ) dut12 (
        .clk(clk), .reset(reset), .cfg_valid(v12), .cfg_ready(rdy12),
        .cfg_addr(addr12), .cfg_data(data12), .cfg_last(last12),
        .clear_start(clr12), .config_data(cdata12), .config_en(en12),
        .busy(busy12), .done(done12), .err(err12)
    );

    typedef struct {
        logic [15:0] en;
        logic [31:0] data;
        logic        done;
        int          gap;   // cycles since previous output event, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;

    task automatic push(input logic [15:0] en, input logic [31:0] data, input logic dn,
                        input int gap);
        exp_t e;
        e.en = en; e.data = data; e.done = dn; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe or done pulse of the main instance is one event.
    initial begin
        exp_t e;
        int   cyc;
        int   last_evt;
        int   gap;
        cyc = 0;
        last_evt = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                chk("en_onehot0", 32'($onehot0(config_en)), 32'd1);
                if (config_en == '0) chk("data_zero_no_strobe", config_data, 32'd0);
                if (config_en != '0 || done) begin
                    gap = cyc - last_evt;
                    last_evt = cyc;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_output: en=%h data=%h done=%b",
                                 config_en, config_data, done);
                    end else begin
                        e = exp_q.pop_front();
                        if (config_en !== e.en || config_data !== e.data || done !== e.done ||
                            (e.gap >= 0 && gap != e.gap)) begin
                            n_bad++;
                            $display("FAIL sb_event: got en=%h data=%h done=%b gap=%0d, want en=%h data=%h done=%b gap=%0d",
                                     config_en, config_data, done, gap, e.en, e.data, e.done, e.gap);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int waits;

        reset = 1; cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_last = 0; clear_start = 0;
        v12 = 0; addr12 = 0; data12 = 0; last12 = 0; clr12 = 0;
        repeat (3) tick();
        reset = 0;

        // Reset state, first cycle after release.
        @(negedge clk);
        chk("rst_config_en", 32'(config_en), 32'd0);
        chk("rst_config_data", config_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        mon_en = 1;
        tick();

        // Single write, addr 3, last.
        cfg_valid = 1; cfg_addr = 4'd3; cfg_data = 32'hA5A5_0F0F; cfg_last = 1;
        push(16'h0008, 32'hA5A5_0F0F, 1'b0, -1);
        push(16'h0000, 32'h0, 1'b1, 3);
        tick();
        cfg_valid = 0;
        @(negedge clk); chk("single_busy_write", 32'(busy), 32'd1);
        tick(); @(negedge clk); chk("single_ready_settle1", 32'(cfg_ready), 32'd0);
        tick(); @(negedge clk); chk("single_ready_settle2", 32'(cfg_ready), 32'd0);
        tick(); @(negedge clk); chk("single_ready_after", 32'(cfg_ready), 32'd1);
        repeat (3) tick();

        // Back-to-back with cfg_valid held: addr 0 then 15.
        cfg_valid = 1; cfg_addr = 4'd0; cfg_data = 32'h1111_0000; cfg_last = 0;
        push(16'h0001, 32'h1111_0000, 1'b0, -1);
        push(16'h8000, 32'h2222_FFFF, 1'b0, 4);
        push(16'h0000, 32'h0, 1'b1, 3);
        tick();
        cfg_addr = 4'd15; cfg_data = 32'h2222_FFFF; cfg_last = 1;
        ok = 0; waits = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1;
            else begin
                waits++;
                tick();
            end
        end
        chk("b2b_second_accepted", 32'(ok), 32'd1);
        chk("b2b_ready_wait", 32'(waits), 32'd3);
        tick();
        cfg_valid = 0;
        repeat (6) tick();

        // Bulk clear.
        clear_start = 1;
        @(negedge clk); chk("clear_ready_low", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 16; i++) push(16'h0001 << i, ClrVal, 1'b0, (i == 0) ? -1 : 1);
        push(16'h0000, 32'h0, 1'b1, 1);
        tick();
        clear_start = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); chk("clear_busy", 32'(busy), 32'd1);
            tick();
        end
        @(negedge clk); chk("clear_busy_after", 32'(busy), 32'd0);
        repeat (3) tick();

        // Priority: clear_start and cfg_valid together, clear wins.
        clear_start = 1; cfg_valid = 1; cfg_addr = 4'd2; cfg_data = 32'h0BAD_0BAD; cfg_last = 1;
        @(negedge clk); chk("prio_ready_low", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 16; i++) push(16'h0001 << i, ClrVal, 1'b0, (i == 0) ? -1 : 1);
        push(16'h0000, 32'h0, 1'b1, 1);
        tick();
        clear_start = 0; cfg_valid = 0;
        repeat (19) tick();

        // Range error on 12-tile instance.
        v12 = 1; addr12 = 4'd15; data12 = 32'h1234_5678; last12 = 1;
        tick();
        v12 = 0;
        @(negedge clk);
        chk("range_err_set", 32'(err12), 32'd1);
        chk("range_done_pulse", 32'(done12), 32'd1);
        chk("range_no_strobe", 32'(en12), 32'd0);
        chk("range_stays_idle", 32'(busy12), 32'd0);
        tick(); @(negedge clk);
        chk("range_done_one_cycle", 32'(done12), 32'd0);
        chk("range_err_sticky", 32'(err12), 32'd1);
        v12 = 1; addr12 = 4'd11; data12 = 32'hCAFE_F00D; last12 = 0;
        tick();
        v12 = 0;
        @(negedge clk);
        chk("range_top_tile_strobe", 32'(en12), 32'h800);
        chk("range_top_tile_data", cdata12, 32'hCAFE_F00D);
        repeat (4) tick();
        clr12 = 1;
        tick();
        clr12 = 0;
        @(negedge clk);
        chk("range_clear_clears_err", 32'(err12), 32'd0);
        chk("range_clear_first_strobe", 32'(en12), 32'h001);
        repeat (14) tick();

        // Reset in the middle of a clear, at counter 5.
        clear_start = 1;
        v12 = 1; addr12 = 4'd13; last12 = 0;
        for (int i = 0; i < 6; i++) push(16'h0001 << i, ClrVal, 1'b0, (i == 0) ? -1 : 1);
        tick();
        clear_start = 0; v12 = 0;
        repeat (5) tick();
        @(negedge clk);
        chk("midclr_err12_before", 32'(err12), 32'd1);
        reset = 1;
        tick();
        @(negedge clk);
        chk("midclr_config_en", 32'(config_en), 32'd0);
        chk("midclr_config_data", config_data, 32'd0);
        chk("midclr_done", 32'(done), 32'd0);
        chk("midclr_busy", 32'(busy), 32'd0);
        chk("midclr_err12_cleared", 32'(err12), 32'd0);
        reset = 0;
        tick();
        @(negedge clk);
        chk("midclr_ready_after", 32'(cfg_ready), 32'd1);
        chk("midclr_no_done", 32'(done), 32'd0);
        repeat (5) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
